// File: rtl/sodor_obs_sink.sv
// Consumer of the six *_obs_src observation channels from two lockstep Sodor tiles.
// Optional SODOR_OBS_SINK_CAPTURE_EN adds the first-mismatch argument capture outputs.
module sodor_obs_sink #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 21,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              l_PC_obs_src_cond,
  input  logic [DATA_W-1:0] l_PC_obs_src_arg0,
  input  logic              l_INSTR_obs_src_cond,
  input  logic [DATA_W-1:0] l_INSTR_obs_src_arg0,
  input  logic              l_WADDR_obs_src_cond,
  input  logic [ADDR_W-1:0] l_WADDR_obs_src_arg0,
  input  logic              l_WDATA_obs_src_cond,
  input  logic [DATA_W-1:0] l_WDATA_obs_src_arg0,
  input  logic              l_RADDR_obs_src_cond,
  input  logic [ADDR_W-1:0] l_RADDR_obs_src_arg0,
  input  logic              l_RDATA_obs_src_cond,
  input  logic [DATA_W-1:0] l_RDATA_obs_src_arg0,
  input  logic              r_PC_obs_src_cond,
  input  logic [DATA_W-1:0] r_PC_obs_src_arg0,
  input  logic              r_INSTR_obs_src_cond,
  input  logic [DATA_W-1:0] r_INSTR_obs_src_arg0,
  input  logic              r_WADDR_obs_src_cond,
  input  logic [ADDR_W-1:0] r_WADDR_obs_src_arg0,
  input  logic              r_WDATA_obs_src_cond,
  input  logic [DATA_W-1:0] r_WDATA_obs_src_arg0,
  input  logic              r_RADDR_obs_src_cond,
  input  logic [ADDR_W-1:0] r_RADDR_obs_src_arg0,
  input  logic              r_RDATA_obs_src_cond,
  input  logic [DATA_W-1:0] r_RDATA_obs_src_arg0,
  output logic              mismatch,
  output logic [2:0]        mismatch_chan,
  output logic              overflow,
  output logic              drained
`ifdef SODOR_OBS_SINK_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] mm_left_data,
  output logic [DATA_W-1:0] mm_right_data
`endif
);

  localparam int NCH   = 6;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NCH-1:0]    l_cond_s;
  logic [NCH-1:0]    r_cond_s;
  logic [DATA_W-1:0] l_arg_s [NCH];
  logic [DATA_W-1:0] r_arg_s [NCH];

  logic [DATA_W-1:0] mem_r    [NCH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r [NCH];
  logic [PTR_W-1:0]  rd_ptr_r [NCH];
  logic [CNT_W-1:0]  cnt_r    [NCH];
  logic [NCH-1:0]    lead_r;

  logic [DATA_W-1:0] head_s      [NCH];
  logic [DATA_W-1:0] push_data_s [NCH];
  logic [DATA_W-1:0] cmp_l_s     [NCH];
  logic [DATA_W-1:0] cmp_r_s     [NCH];
  logic [NCH-1:0]    empty_s;
  logic [NCH-1:0]    full_s;
  logic [NCH-1:0]    push_s;
  logic [NCH-1:0]    pop_s;
  logic [NCH-1:0]    cmp_s;
  logic [NCH-1:0]    lead_nxt_s;
  logic [NCH-1:0]    accept_s;
  logic [NCH-1:0]    drop_s;
  logic [NCH-1:0]    fail_s;
  logic [2:0]        fail_idx_s;
  logic [DATA_W-1:0] fail_l_s;
  logic [DATA_W-1:0] fail_r_s;

  // Gather the named ports into channel-indexed vectors; address args are zero-extended.
  always_comb begin
    l_cond_s   = {l_RDATA_obs_src_cond, l_RADDR_obs_src_cond, l_WDATA_obs_src_cond,
                  l_WADDR_obs_src_cond, l_INSTR_obs_src_cond, l_PC_obs_src_cond};
    r_cond_s   = {r_RDATA_obs_src_cond, r_RADDR_obs_src_cond, r_WDATA_obs_src_cond,
                  r_WADDR_obs_src_cond, r_INSTR_obs_src_cond, r_PC_obs_src_cond};
    l_arg_s[0] = l_PC_obs_src_arg0;
    l_arg_s[1] = l_INSTR_obs_src_arg0;
    l_arg_s[2] = DATA_W'(l_WADDR_obs_src_arg0);
    l_arg_s[3] = l_WDATA_obs_src_arg0;
    l_arg_s[4] = DATA_W'(l_RADDR_obs_src_arg0);
    l_arg_s[5] = l_RDATA_obs_src_arg0;
    r_arg_s[0] = r_PC_obs_src_arg0;
    r_arg_s[1] = r_INSTR_obs_src_arg0;
    r_arg_s[2] = DATA_W'(r_WADDR_obs_src_arg0);
    r_arg_s[3] = r_WDATA_obs_src_arg0;
    r_arg_s[4] = DATA_W'(r_RADDR_obs_src_arg0);
    r_arg_s[5] = r_RDATA_obs_src_arg0;
  end

  // Per-channel event decode: decide push/pop/compare and which values form the compared pair.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      head_s[i]      = mem_r[i][rd_ptr_r[i]];
      empty_s[i]     = (cnt_r[i] == CNT_W'(0));
      full_s[i]      = (cnt_r[i] == CNT_W'(DEPTH));
      push_s[i]      = 1'b0;
      pop_s[i]       = 1'b0;
      cmp_s[i]       = 1'b0;
      lead_nxt_s[i]  = lead_r[i];
      push_data_s[i] = l_arg_s[i];
      cmp_l_s[i]     = l_arg_s[i];
      cmp_r_s[i]     = r_arg_s[i];
      // A popped head always stands in for the leading side of the pair.
      case ({l_cond_s[i], r_cond_s[i]})
        2'b11: begin
          cmp_s[i] = 1'b1;
          if (empty_s[i]) begin
            pop_s[i]  = 1'b0;
          end else begin
            pop_s[i]       = 1'b1;
            push_s[i]      = 1'b1;
            push_data_s[i] = lead_r[i] ? r_arg_s[i] : l_arg_s[i];
            cmp_l_s[i]     = lead_r[i] ? l_arg_s[i] : head_s[i];
            cmp_r_s[i]     = lead_r[i] ? head_s[i]  : r_arg_s[i];
          end
        end
        2'b10: begin
          if (empty_s[i] || !lead_r[i]) begin
            push_s[i]      = 1'b1;
            push_data_s[i] = l_arg_s[i];
            lead_nxt_s[i]  = 1'b0;
          end else begin
            pop_s[i]   = 1'b1;
            cmp_s[i]   = 1'b1;
            cmp_r_s[i] = head_s[i];
          end
        end
        2'b01: begin
          if (empty_s[i] || lead_r[i]) begin
            push_s[i]      = 1'b1;
            push_data_s[i] = r_arg_s[i];
            lead_nxt_s[i]  = 1'b1;
          end else begin
            pop_s[i]   = 1'b1;
            cmp_s[i]   = 1'b1;
            cmp_l_s[i] = head_s[i];
          end
        end
        default: begin
          lead_nxt_s[i] = lead_r[i];
        end
      endcase
      accept_s[i] = push_s[i] && (!full_s[i] || pop_s[i]);
      drop_s[i]   = push_s[i] && full_s[i] && !pop_s[i];
      fail_s[i]   = cmp_s[i] && (cmp_l_s[i] != cmp_r_s[i]);
    end
  end

  // Lowest failing channel this cycle, scanned from the top so index 0 has priority.
  always_comb begin
    fail_idx_s = 3'd0;
    fail_l_s   = {DATA_W{1'b0}};
    fail_r_s   = {DATA_W{1'b0}};
    for (int i = NCH - 1; i >= 0; i--) begin
      fail_idx_s = fail_s[i] ? 3'(i)      : fail_idx_s;
      fail_l_s   = fail_s[i] ? cmp_l_s[i] : fail_l_s;
      fail_r_s   = fail_s[i] ? cmp_r_s[i] : fail_r_s;
    end
  end

  // Skew buffer pointers, occupancy and lead side.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        cnt_r[i]    <= {CNT_W{1'b0}};
      end
      lead_r <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
        end
        case ({accept_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
      lead_r <= lead_nxt_s;
    end
  end

  // Skew buffer storage; contents are only meaningful below cnt, so no reset is needed.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= push_data_s[i];
      end
    end
  end

  // Sticky status flags and first-failure channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch      <= 1'b0;
      mismatch_chan <= 3'd0;
      overflow      <= 1'b0;
    end else begin
      if (|fail_s) begin
        mismatch <= 1'b1;
      end
      if ((|fail_s) && !mismatch) begin
        mismatch_chan <= fail_idx_s;
      end
      if (|drop_s) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SODOR_OBS_SINK_CAPTURE_EN
  // Capture the compared pair that caused the first mismatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      mm_left_data  <= {DATA_W{1'b0}};
      mm_right_data <= {DATA_W{1'b0}};
    end else if ((|fail_s) && !mismatch) begin
      mm_left_data  <= fail_l_s;
      mm_right_data <= fail_r_s;
    end
  end
`else
  // Without capture the failing pair is only used to detect the mismatch itself.
  logic unused_fail_data_s;
  assign unused_fail_data_s = ^{fail_l_s, fail_r_s};
`endif

  // Drained whenever every channel's occupancy is zero after the last edge.
  always_comb begin
    drained = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      drained = drained & (cnt_r[i] == CNT_W'(0));
    end
  end

endmodule

// File: tb/tb_sodor_obs_sink.sv
// Self-checking bench for sodor_obs_sink: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_sodor_obs_sink;

  localparam int DEPTH = 4;

  logic              clock;
  logic              reset;
  logic [5:0]        lc, rc;
  logic [5:0][31:0]  la, ra;
  logic              mismatch;
  logic [2:0]        mismatch_chan;
  logic              overflow;
  logic              drained;
`ifdef SODOR_OBS_SINK_CAPTURE_EN
  logic [31:0]       mm_left_data, mm_right_data;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] q [6][$];
  bit          lead_m [6];
  logic        mm_m;
  logic [2:0]  ch_m;
  logic        ov_m;
  logic [31:0] ml_m, mr_m;

  sodor_obs_sink #(.DATA_W(32), .ADDR_W(21), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .l_PC_obs_src_cond(lc[0]),    .l_PC_obs_src_arg0(la[0]),
    .l_INSTR_obs_src_cond(lc[1]), .l_INSTR_obs_src_arg0(la[1]),
    .l_WADDR_obs_src_cond(lc[2]), .l_WADDR_obs_src_arg0(la[2][20:0]),
    .l_WDATA_obs_src_cond(lc[3]), .l_WDATA_obs_src_arg0(la[3]),
    .l_RADDR_obs_src_cond(lc[4]), .l_RADDR_obs_src_arg0(la[4][20:0]),
    .l_RDATA_obs_src_cond(lc[5]), .l_RDATA_obs_src_arg0(la[5]),
    .r_PC_obs_src_cond(rc[0]),    .r_PC_obs_src_arg0(ra[0]),
    .r_INSTR_obs_src_cond(rc[1]), .r_INSTR_obs_src_arg0(ra[1]),
    .r_WADDR_obs_src_cond(rc[2]), .r_WADDR_obs_src_arg0(ra[2][20:0]),
    .r_WDATA_obs_src_cond(rc[3]), .r_WDATA_obs_src_arg0(ra[3]),
    .r_RADDR_obs_src_cond(rc[4]), .r_RADDR_obs_src_arg0(ra[4][20:0]),
    .r_RDATA_obs_src_cond(rc[5]), .r_RDATA_obs_src_arg0(ra[5]),
    .mismatch(mismatch), .mismatch_chan(mismatch_chan),
    .overflow(overflow), .drained(drained)
`ifdef SODOR_OBS_SINK_CAPTURE_EN
    , .mm_left_data(mm_left_data), .mm_right_data(mm_right_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             rst;
    logic [5:0]       lc, rc;
    logic [5:0][31:0] la, ra;
    logic             em;
    logic [2:0]       ec;
    logic             eo, ed;
    logic [31:0]      eml, emr;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic rst, logic [5:0] l, logic [5:0] r, logic [31:0] lv,
                              logic [31:0] rv, logic em, logic [2:0] ec, logic eo,
                              logic ed, logic [31:0] eml, logic [31:0] emr);
    vec_t t;
    t.rst = rst; t.lc = l; t.rc = r;
    for (int i = 0; i < 6; i++) begin
      t.la[i] = lv;
      t.ra[i] = rv;
    end
    t.em = em; t.ec = ec; t.eo = eo; t.ed = ed; t.eml = eml; t.emr = emr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(int c, logic [31:0] v);
    return (c == 2 || c == 4) ? (v & 32'h001F_FFFF) : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 6; c++) begin
      q[c].delete();
      lead_m[c] = 1'b0;
    end
    mm_m = 1'b0; ch_m = 3'd0; ov_m = 1'b0; ml_m = 32'd0; mr_m = 32'd0;
  endtask

  // One cycle of the pairing rules, expressed over arrival queues.
  task automatic model_step();
    logic        any;
    int          first;
    logic [31:0] fl, fr;
    any = 1'b0; first = 0; fl = 32'd0; fr = 32'd0;
    for (int c = 0; c < 6; c++) begin
      logic [31:0] lv, rv, hd, pl, pr;
      logic        cmp;
      bit          side;
      lv = ext(c, la[c]); rv = ext(c, ra[c]); cmp = 1'b0; pl = 32'd0; pr = 32'd0;
      if (lc[c] && rc[c]) begin
        cmp = 1'b1;
        if (q[c].size() == 0) begin
          pl = lv; pr = rv;
        end else begin
          hd = q[c].pop_front();
          if (lead_m[c]) begin pl = lv; pr = hd; q[c].push_back(rv); end
          else begin pl = hd; pr = rv; q[c].push_back(lv); end
        end
      end else if (lc[c] || rc[c]) begin
        side = rc[c];
        if (q[c].size() == 0 || side == lead_m[c]) begin
          if (q[c].size() == DEPTH) ov_m = 1'b1;
          else q[c].push_back(side ? rv : lv);
          lead_m[c] = side;
        end else begin
          hd  = q[c].pop_front();
          cmp = 1'b1;
          if (side) begin pl = hd; pr = rv; end
          else begin pl = lv; pr = hd; end
        end
      end
      if (cmp && pl != pr && !any) begin
        any = 1'b1; first = c; fl = pl; fr = pr;
      end
    end
    if (any && !mm_m) begin
      ch_m = 3'(first); ml_m = fl; mr_m = fr;
    end
    if (any) mm_m = 1'b1;
  endtask

  function automatic logic model_drained();
    logic d;
    d = 1'b1;
    for (int c = 0; c < 6; c++) d = d & (q[c].size() == 0);
    return d;
  endfunction

  task automatic step(input logic r, input logic [5:0] lcv, input logic [5:0] rcv,
                      input logic [5:0][31:0] lav, input logic [5:0][31:0] rav);
    reset = r; lc = lcv; rc = rcv; la = lav; ra = rav;
    if (r) model_reset();
    else model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " mismatch"}, 32'(mismatch), 32'(mm_m));
    chk({tag, " chan"},     32'(mismatch_chan), 32'(ch_m));
    chk({tag, " overflow"}, 32'(overflow), 32'(ov_m));
    chk({tag, " drained"},  32'(drained), 32'(model_drained()));
`ifdef SODOR_OBS_SINK_CAPTURE_EN
    chk({tag, " mm_left"},  mm_left_data, ml_m);
    chk({tag, " mm_right"}, mm_right_data, mr_m);
`endif
  endtask

  initial begin
    vec_t             t;
    logic [5:0][31:0] lav, rav;
    logic [5:0]       lcv, rcv;
    int               lseq [6];
    int               rseq [6];

    reset = 1'b1; lc = '0; rc = '0; la = '0; ra = '0;
    model_reset();

    // directed table: skew, divergence, overflow, push+pop wrap, pop mismatch, mid reset
    tbl.push_back(mk(1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 6'h08, 6'h00, 32'h11, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h08, 6'h00, 32'h22, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h08, 6'h00, 32'h33, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 6'h08, 0, 32'h11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 6'h08, 0, 32'h22, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 6'h08, 0, 32'h33, 0, 0, 0, 1, 0, 0));
    t = mk(0, 6'h12, 6'h12, 32'hAAAA, 32'hBBBB, 1, 1, 0, 1, 32'hAAAA, 32'hBBBB);
    t.la[4] = 32'h1000; t.ra[4] = 32'h1004;
    tbl.push_back(t);
    tbl.push_back(mk(1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 6'h20, 6'h00, 32'(k), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h20, 6'h00, 32'd5, 0, 0, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(0, 6'h00, 6'h20, 0, 32'(k), 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 6'h20, 0, 32'd4, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 6'h04, 6'h00, 32'h100, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h04, 6'h00, 32'h104, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 6'h04, 6'h04, 32'h108 + 32'(4 * k), 32'h100 + 32'(4 * k), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 6'h04, 0, 32'h128, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 6'h04, 0, 32'h12C, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 6'h00, 6'h01, 0, 32'h7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h01, 6'h00, 32'h8, 0, 1, 0, 0, 1, 32'h8, 32'h7));
    tbl.push_back(mk(0, 6'h20, 6'h20, 32'h1, 32'h2, 1, 0, 0, 1, 32'h8, 32'h7));
    tbl.push_back(mk(1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(0, 6'h01, 6'h00, 32'(k), 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6'h00, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 6'h01, 6'h01, 0, 0, 0, 0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].lc, tbl[i].rc, tbl[i].la, tbl[i].ra);
      chk($sformatf("row%0d mismatch", i), 32'(mismatch), 32'(tbl[i].em));
      chk($sformatf("row%0d chan", i), 32'(mismatch_chan), 32'(tbl[i].ec));
      chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].eo));
      chk($sformatf("row%0d drained", i), 32'(drained), 32'(tbl[i].ed));
`ifdef SODOR_OBS_SINK_CAPTURE_EN
      chk($sformatf("row%0d mm_left", i), mm_left_data, tbl[i].eml);
      chk($sformatf("row%0d mm_right", i), mm_right_data, tbl[i].emr);
`endif
    end

    // lockstep PC stream
    step(1'b1, 6'h00, 6'h00, '0, '0);
    for (int k = 0; k < 20; k++) begin
      lav = '0; lav[0] = 32'(4 * k);
      step(1'b0, 6'h01, 6'h01, lav, lav);
      chk($sformatf("lockstep%0d mismatch", k), 32'(mismatch), 32'd0);
      chk($sformatf("lockstep%0d drained", k), 32'(drained), 32'd1);
    end

    // randomized skewed traffic with rare corruption, periodic resets
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        for (int c = 0; c < 6; c++) begin lseq[c] = 0; rseq[c] = 0; end
        step(1'b1, 6'h00, 6'h00, '0, '0);
      end else begin
        lav = '0; rav = '0;
        for (int c = 0; c < 6; c++) begin
          lcv[c] = 1'($urandom_range(0, 1));
          rcv[c] = 1'($urandom_range(0, 1));
          if (q[c].size() >= DEPTH - 1 && $urandom_range(0, 3) != 0) begin
            if (lead_m[c]) rcv[c] = 1'b0;
            else lcv[c] = 1'b0;
          end
          lav[c] = (32'(c) << 16) | 32'(lseq[c] * 4);
          rav[c] = (32'(c) << 16) | 32'(rseq[c] * 4);
          if ($urandom_range(0, 199) == 0) lav[c] = lav[c] ^ 32'h1;
          if (lcv[c]) lseq[c]++;
          if (rcv[c]) rseq[c]++;
        end
        step(1'b0, lcv, rcv, lav, rav);
      end
      chk_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sodor_obs_sink.md
# sodor_obs_sink

Consumer end of the `*_obs_src` observation channels of the Sodor 1-stage tile. The block receives the six observation channels (PC, INSTR, WADDR, WDATA, RADDR, RDATA) from two tile instances, left and right, running in the relational (two-copy) harness. For each channel it buffers whichever side is ahead and compares the two streams in order. It reports a sticky mismatch, the first failing channel, buffer overflow, and a drained status to the harness assertions.

## Interface
Parameters:
- `DATA_W`, 32, width of PC/INSTR/WDATA/RDATA arguments
- `ADDR_W`, 21, width of WADDR/RADDR arguments
- `DEPTH`, 4, per-channel skew buffer entries (power of two, ≥2)

Ports:
- `clock`  in  1  sole clock; everything is rising-edge
- `reset`  in  1  synchronous, active-high
- `l_<CH>_obs_src_cond`  in  1  left-copy event valid, for each CH ∈ {PC, INSTR, WADDR, WDATA, RADDR, RDATA}
- `l_<CH>_obs_src_arg0`  in  DATA_W or ADDR_W  left-copy argument (ADDR_W for WADDR/RADDR)
- `r_<CH>_obs_src_cond`, `r_<CH>_obs_src_arg0`  in  same  right-copy equivalents
- `mismatch`  out  1  sticky: some compared pair differed
- `mismatch_chan`  out  3  channel of the first mismatch (0 PC, 1 INSTR, 2 WADDR, 3 WDATA, 4 RADDR, 5 RDATA)
- `overflow`  out  1  sticky: a push found its buffer full
- `drained`  out  1  all six buffers empty

## Operation
- Each channel is independent and has:
  - a FIFO of `DEPTH` arguments;
  - a count `cnt` (0..DEPTH);
  - a lead flag `lead` (0 left, 1 right); `lead` is meaningful only when `cnt>0`.
- Per-cycle event cases, with `a`=left cond and `b`=right cond:
  - `a && b`, `cnt==0`: compare `l_arg` with `r_arg`. No state change.
  - `a && b`, `cnt>0`: pop the head and compare it with the trailing side's arg. Push the leading side's arg in the same cycle. `cnt` and `lead` are unchanged.
  - exactly one side fires, and `cnt==0` or that side equals `lead`: push its arg and set `lead` to that side.
  - exactly one side fires, `cnt>0`, and that side is not `lead`: pop the head, compare it with that arg, `cnt-1`.
  - neither side fires: hold.
- Push when `cnt==DEPTH` and no pop in the same cycle:
  - the entry is dropped and `overflow` is set;
  - `cnt` stays `DEPTH`;
  - later comparisons on that channel are not meaningful.
- Compare failure:
  - sets `mismatch`.
  - If `mismatch` was previously 0, `mismatch_chan` is loaded with the channel index.
  - If several channels fail in the same cycle, the lowest index wins.
- FIFO pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. `cnt` is `log2(DEPTH)+1` bits.
- `mismatch` and `overflow` are cleared only by `reset`.

## Timing
- Reset values: `mismatch`=0, `mismatch_chan`=0, `overflow`=0, `drained`=1; all counts 0, pointers 0, leads 0.
- `reset` asserted mid-stream empties every buffer on the next edge. Pending entries are discarded and not compared.
- Comparison occurs in the event cycle. `mismatch`/`mismatch_chan` are registered and visible the cycle after the failing event.
- `overflow` is registered and visible the cycle after the dropped push.
- `drained` is combinational from the counts, so it reflects the count state after the last edge.
- No backpressure: inputs are accepted every cycle unconditionally.

## Configuration
- `SODOR_OBS_SINK_CAPTURE_EN` defined:
  - adds outputs `mm_left_data` and `mm_right_data` (both out, DATA_W, reset 0);
  - they load on the same edge and under the same first-mismatch rule as `mismatch_chan`;
  - ADDR_W arguments are zero-extended.
- Macro undefined: these ports and their registers are absent. All other behaviour is identical.

## Test plan
- Lockstep: both copies fire PC every cycle with an equal incrementing arg 0x0,0x4,… for 20 cycles -> `mismatch`=0, `drained`=1 throughout.
- Skew: left fires WDATA 0x11,0x22,0x33 on cycles 0-2; right fires the same on cycles 3-5 -> WDATA `cnt` peaks at 3 and returns to 0 at cycle 6, `mismatch`=0.
- Divergence: RADDR left 0x1000, right 0x1004 in the same cycle, with a simultaneous INSTR mismatch -> next cycle `mismatch`=1 and `mismatch_chan`=1 (INSTR wins); with the macro defined, the captured data equals the INSTR args.
- Overflow: left fires RDATA 5 times with right silent, `DEPTH`=4 -> `overflow`=1 the cycle after the 5th event, `cnt`=4.
- Push+pop: left leads by 2 on WADDR, then both fire for 10 cycles -> `cnt` stays 2, pairs compare correctly across pointer wrap.
- Reset mid-operation: 3 entries pending on PC, then `reset` is pulsed for 1 cycle -> `drained`=1 the next cycle; a subsequent lockstep run stays clean.
